seq_divider: RTL
================

Name: seq_divider

Overview:
Iterative radix-2 restoring divider, parametrised in operand width. It is the sequential successor to the 16-bit combinational divider.
- Produces one quotient bit per clock, trading latency for area and timing.
- Valid/ready handshakes on both the operand side and the result side.
- Used where a full-width combinational divide cannot meet the clock period.

Parameters:
WORD_WIDTH, 16, operand/result width in bits (>= 2)
CNT_WIDTH, $clog2(WORD_WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  clock, all state updates on posedge
reset_n  input  1  synchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  divider accepts operands
lop  input  WORD_WIDTH  dividend
rop  input  WORD_WIDTH  divisor
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
quot  output  WORD_WIDTH  quotient
mod  output  WORD_WIDTH  remainder
div_by_zero  output  1  result came from rop==0, valid with out_valid
busy  output  1  state != IDLE

Behaviour:
- Reset (reset_n==0 at posedge): state=IDLE; out_valid=0; quot=0; mod=0; div_by_zero=0; counter=0. Any operation in flight is discarded, with no partial result.
- States are IDLE, CALC and DONE. in_ready = (state==IDLE), combinational from state only.
- IDLE: on posedge with in_valid&&in_ready:
  - If rop!=0: latch lop into the quotient shift register, rop into the divisor register, clear the partial remainder, counter=WORD_WIDTH, go to CALC.
  - If rop==0: go directly to DONE with quot = all ones, mod = lop, div_by_zero=1.
- CALC, per cycle:
  - Shift {rem, q} left 1.
  - trial = rem_shifted - divisor, computed WORD_WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial, q LSB = 1. Otherwise rem is unchanged and q LSB = 0.
  - Decrement counter. When counter reaches 1 at the edge, the final iteration completes and state goes to DONE.
- Latency: handshake at edge E0, out_valid high after edge E0+WORD_WIDTH (WORD_WIDTH cycles). Divide-by-zero: out_valid high after E0+1.
- DONE: out_valid=1. quot, mod and div_by_zero are held stable while out_valid && !out_ready. On posedge with out_ready=1: out_valid=0, state=IDLE.
  - quot, mod and div_by_zero retain their values until the next result; only out_valid drops.
  - Next acceptance is possible no earlier than the following edge, so there is no same-cycle turnaround.
- in_valid and operand changes during CALC/DONE are ignored, because in_ready=0.
- Unsigned arithmetic by default, with results exact for all operands: quot = floor(lop/rop), mod = lop - quot*rop.
- lop < rop gives quot=0, mod=lop. rop==1 gives quot=lop, mod=0.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On acceptance, magnitudes are latched along with the sign flags q_neg = lop_msb ^ rop_msb and r_neg = lop_msb.
  - Sign correction is applied on the CALC->DONE edge, so latency is unchanged.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow: MIN/-1 gives quot=MIN, mod=0, and div_by_zero=0.
  - Divide by zero gives quot=all ones (-1), mod=lop.
- Undefined: pure unsigned, with no sign logic synthesised.

Test Plan:
- WORD_WIDTH=16: lop=5, rop=3 -> quot=1, mod=2, div_by_zero=0, out_valid exactly 16 cycles after handshake.
- Back-to-back 45/13 then 20/5 with out_ready=1 -> 3/6 then 4/0; in_ready low throughout CALC/DONE; second accept is 1 cycle after the first out handshake.
- lop=0xFFFF, rop=1 -> quot=0xFFFF, mod=0. lop=7, rop=0x00FF -> quot=0, mod=7. lop=0x1234, rop=0 -> quot=0xFFFF, mod=0x1234, div_by_zero=1, out_valid 1 cycle after accept.
- Backpressure: 100/7 with out_ready=0 for 5 cycles after out_valid -> quot=14, mod=2 held stable, out_valid held, in_ready=0; released on the first out_ready=1 edge.
- Reset mid-op: accept 45/13, assert reset_n=0 at iteration 8 -> next edge state=IDLE, out_valid=0, quot=0, mod=0, in_ready=1; a new op 20/5 then yields 4/0.
- With SEQ_DIVIDER_SIGNED_EN: -45/13 -> quot=-3 (0xFFFD), mod=-6 (0xFFFA); 45/-13 -> -3, 6; 0x8000/0xFFFF -> quot=0x8000, mod=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset_n      synchronous active-low reset
//   in_valid     operands present           in_ready     divider accepts operands
//   lop          dividend                   rop          divisor
//   out_valid    result present             out_ready    consumer accepts result
//   quot         quotient                   mod          remainder
//   div_by_zero  result came from rop==0    busy         state != IDLE
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   -> two's complement operands. The quotient truncates toward zero and the
//                remainder takes the dividend's sign.
//   undefined -> pure unsigned; no sign logic is built.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one restoring iteration per cycle, r_cnt iterations remaining
// DONE  | result presented, held until out_ready

module seq_divider #(
  parameter int WORD_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] lop,
  input  logic [WORD_WIDTH-1:0] rop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] quot,
  output logic [WORD_WIDTH-1:0] mod,
  output logic                  div_by_zero,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_q;
  logic [WORD_WIDTH-1:0] r_rem;
  logic [WORD_WIDTH-1:0] r_div;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [WORD_WIDTH-1:0] r_quot;
  logic [WORD_WIDTH-1:0] r_mod;
  logic                  r_dbz;
  logic                  r_out_valid;

  logic [WORD_WIDTH-1:0] w_lop_mag;
  logic [WORD_WIDTH-1:0] w_rop_mag;
  logic [WORD_WIDTH:0]   w_rem_sh;
  logic [WORD_WIDTH:0]   w_trial;
  logic [WORD_WIDTH-1:0] w_rem_next;
  logic [WORD_WIDTH-1:0] w_q_next;
  logic [WORD_WIDTH-1:0] w_quot_fix;
  logic [WORD_WIDTH-1:0] w_mod_fix;

  // Partial remainder is always below the divisor, so the shifted value is
  // below 2*divisor and the trial difference fits in WORD_WIDTH+1 signed bits.
  assign w_rem_sh   = {r_rem, r_q[WORD_WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_div};
  assign w_rem_next = w_trial[WORD_WIDTH] ? w_rem_sh[WORD_WIDTH-1:0] : w_trial[WORD_WIDTH-1:0];
  assign w_q_next   = {r_q[WORD_WIDTH-2:0], ~w_trial[WORD_WIDTH]};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_q_neg;
  logic r_r_neg;

  // MIN maps to itself, which read unsigned is exactly its magnitude; MIN/-1
  // therefore falls out as quot=MIN, mod=0 with no special case.
  assign w_lop_mag  = lop[WORD_WIDTH-1] ? WORD_WIDTH'(~lop + 1'b1) : lop;
  assign w_rop_mag  = rop[WORD_WIDTH-1] ? WORD_WIDTH'(~rop + 1'b1) : rop;
  assign w_quot_fix = r_q_neg ? WORD_WIDTH'(~w_q_next + 1'b1) : w_q_next;
  assign w_mod_fix  = r_r_neg ? WORD_WIDTH'(~w_rem_next + 1'b1) : w_rem_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_q_neg <= lop[WORD_WIDTH-1] ^ rop[WORD_WIDTH-1];
      r_r_neg <= lop[WORD_WIDTH-1];
    end
  end
`else
  assign w_lop_mag  = lop;
  assign w_rop_mag  = rop;
  assign w_quot_fix = w_q_next;
  assign w_mod_fix  = w_rem_next;
`endif

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid;
  assign quot        = r_quot;
  assign mod         = r_mod;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quot      <= '0;
      r_mod       <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (rop == '0) begin
              r_quot  <= '1;
              r_mod   <= lop;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_q     <= w_lop_mag;
              r_div   <= w_rop_mag;
              r_rem   <= '0;
              r_cnt   <= CNT_LOAD;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_WIDTH'(1)) begin
            r_quot      <= w_quot_fix;
            r_mod       <= w_mod_fix;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Divide-by-zero arrives here with out_valid still low; it is raised
          // one cycle later, giving the one-cycle zero-divisor latency.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
